// File: rtl/top_consts_types_package.sv
// Shared instruction field ranges, opcodes and cfg bundle types.
// REFI1/REFI2 layouts are fixed here so decoder and sequencer agree.
package top_consts_types_package;

  localparam int INSTR_CODE_HI = 26;
  localparam int INSTR_CODE_LO = 23;

  localparam int NR_OF_REG_FILE_PORTS_HI = 22;
  localparam int NR_OF_REG_FILE_PORTS_LO = 21;

  localparam int REFI1_START_HI = 20;
  localparam int REFI1_START_LO = 15;
  localparam int REFI1_NR_HI    = 14;
  localparam int REFI1_NR_LO    = 9;
  localparam int REFI1_INIT_HI  = 8;
  localparam int REFI1_INIT_LO  = 3;
  localparam int REFI1_EXT_BIT  = 2;

  localparam int REFI2_STEP_HI  = 22;
  localparam int REFI2_STEP_LO  = 17;
  localparam int REFI2_SIGN_BIT = 16;
  localparam int REFI2_MID_HI   = 15;
  localparam int REFI2_MID_LO   = 10;
  localparam int REFI2_REPT_HI  = 9;
  localparam int REFI2_REPT_LO  = 4;
  localparam int REFI2_RSTEP_HI = 3;
  localparam int REFI2_RSTEP_LO = 0;

  localparam logic [3:0] REFI1_CODE = 4'b0001;
  localparam logic [3:0] REFI2_CODE = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_EXT,
    ST_OUT
  } refi_state_e;

  typedef struct packed {
    logic [1:0] port;
    logic [5:0] start;
    logic [5:0] nr_addrs;
    logic [5:0] init_delay;
    logic [5:0] step;
    logic       step_sign;
    logic [5:0] mid_delay;
    logic [5:0] num_rept;
    logic [3:0] rep_step;
    logic [5:0] end_addr;
    logic       range_err;
  } refi_cfg_t;

endpackage

// File: rtl/refi_end_addr_calc.sv
// Last-address computation: start +/- step*nr_addrs as a 13-bit signed
// value, wrapped to 6 bits, with an out-of-range flag.
module refi_end_addr_calc #(
  parameter int DEPTH = 64
) (
  input  logic [5:0] start,
  input  logic [5:0] nr_addrs,
  input  logic [5:0] step,
  input  logic       step_sign,
  output logic [5:0] end_addr,
  output logic       range_err
);

  logic [11:0] prod;
  logic [12:0] s;

  always_comb begin
    prod = {6'd0, step} * {6'd0, nr_addrs};
    if (step_sign) begin
      s = {7'd0, start} - {1'b0, prod};
    end else begin
      s = {7'd0, start} + {1'b0, prod};
    end
    end_addr  = s[5:0];
    // s[12] set means the signed result went negative
    range_err = s[12] | (s[11:0] > 12'(DEPTH - 1));
  end

endmodule

// File: rtl/refi_decoder.sv
// Assembles REFI1 and optional REFI2 words into one register-file
// AGU configuration, held until the AGU accepts it.
module refi_decoder #(
  parameter int         INSTR_WIDTH         = 27,
  parameter int         REG_FILE_ADDR_WIDTH = 6,
  parameter int         REG_FILE_DEPTH      = 64,
  parameter logic [3:0] REFI1_CODE =
    top_consts_types_package::REFI1_CODE,
  parameter logic [3:0] REFI2_CODE =
    top_consts_types_package::REFI2_CODE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           instr_valid,
  input  logic [INSTR_WIDTH-1:0]         instr,
  output logic                           instr_ready,
  output logic                           cfg_valid,
  input  logic                           cfg_ready,
  output logic [1:0]                     cfg_port,
  output logic [REG_FILE_ADDR_WIDTH-1:0] cfg_start,
  output logic [REG_FILE_ADDR_WIDTH-1:0] cfg_nr_addrs,
  output logic [5:0]                     cfg_init_delay,
  output logic [5:0]                     cfg_step,
  output logic                           cfg_step_sign,
  output logic [5:0]                     cfg_mid_delay,
  output logic [5:0]                     cfg_num_rept,
  output logic [3:0]                     cfg_rep_step,
  output logic [REG_FILE_ADDR_WIDTH-1:0] cfg_end,
  output logic                           cfg_range_err,
  output logic                           err
);

  import top_consts_types_package::*;

  refi_state_e state_q, state_d;
  refi_cfg_t   cfg_q, cfg_d, cfg_n;
  logic        err_q, err_d;
  logic        valid_q;
  logic        ready_q;
  logic        accept;
  logic        is_r1;
  logic        is_r2;
  logic [3:0]  code;
  logic [5:0]  end_addr;
  logic        range_err;

  assign code   = instr[INSTR_CODE_HI:INSTR_CODE_LO];
  assign accept = instr_valid & ready_q;
  assign is_r1  = (code == REFI1_CODE);
  assign is_r2  = (code == REFI2_CODE);

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_WAIT_EXT: begin
        if (accept) begin
          if (state_q == ST_WAIT_EXT && is_r2) begin
            cfg_d.step      = instr[REFI2_STEP_HI:REFI2_STEP_LO];
            cfg_d.step_sign = instr[REFI2_SIGN_BIT];
            cfg_d.mid_delay = instr[REFI2_MID_HI:REFI2_MID_LO];
            cfg_d.num_rept  = instr[REFI2_REPT_HI:REFI2_REPT_LO];
            cfg_d.rep_step  = instr[REFI2_RSTEP_HI:REFI2_RSTEP_LO];
            state_d         = ST_OUT;
          end else begin
            // a broken REFI1/REFI2 pair falls back to IDLE decoding
            err_d   = (state_q == ST_WAIT_EXT) | is_r2;
            state_d = ST_IDLE;
            if (is_r1) begin
              cfg_d.port =
                instr[NR_OF_REG_FILE_PORTS_HI:NR_OF_REG_FILE_PORTS_LO];
              cfg_d.start      = instr[REFI1_START_HI:REFI1_START_LO];
              cfg_d.nr_addrs   = instr[REFI1_NR_HI:REFI1_NR_LO];
              cfg_d.init_delay = instr[REFI1_INIT_HI:REFI1_INIT_LO];
              if (instr[REFI1_EXT_BIT]) begin
                state_d = ST_WAIT_EXT;
              end else begin
                cfg_d.step      = 6'd1;
                cfg_d.step_sign = 1'b0;
                cfg_d.mid_delay = 6'd0;
                cfg_d.num_rept  = 6'd0;
                cfg_d.rep_step  = 4'd0;
                state_d         = ST_OUT;
              end
            end
          end
        end
      end
      ST_OUT: begin
        if (cfg_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  refi_end_addr_calc #(
    .DEPTH(REG_FILE_DEPTH)
  ) u_end_calc (
    .start    (cfg_d.start),
    .nr_addrs (cfg_d.nr_addrs),
    .step     (cfg_d.step),
    .step_sign(cfg_d.step_sign),
    .end_addr (end_addr),
    .range_err(range_err)
  );

  always_comb begin
    cfg_n           = cfg_d;
    cfg_n.end_addr  = end_addr;
    cfg_n.range_err = range_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_n;
      err_q   <= err_d;
      valid_q <= (state_d == ST_OUT);
      ready_q <= (state_d != ST_OUT);
    end
  end

  assign instr_ready    = ready_q;
  assign cfg_valid      = valid_q;
  assign err            = err_q;
  assign cfg_port       = cfg_q.port;
  assign cfg_start      = cfg_q.start;
  assign cfg_nr_addrs   = cfg_q.nr_addrs;
  assign cfg_init_delay = cfg_q.init_delay;
  assign cfg_step       = cfg_q.step;
  assign cfg_step_sign  = cfg_q.step_sign;
  assign cfg_mid_delay  = cfg_q.mid_delay;
  assign cfg_num_rept   = cfg_q.num_rept;
  assign cfg_rep_step   = cfg_q.rep_step;
  assign cfg_end        = cfg_q.end_addr;
  assign cfg_range_err  = cfg_q.range_err;

endmodule

// File: tb/tb_refi_decoder.sv
// Directed bench for refi_decoder with hand-computed expectations.
// Inputs change away from posedge; outputs sampled on negedge.
module tb_refi_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [26:0] instr;
  logic        instr_ready;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_port;
  logic [5:0]  cfg_start;
  logic [5:0]  cfg_nr_addrs;
  logic [5:0]  cfg_init_delay;
  logic [5:0]  cfg_step;
  logic        cfg_step_sign;
  logic [5:0]  cfg_mid_delay;
  logic [5:0]  cfg_num_rept;
  logic [3:0]  cfg_rep_step;
  logic [5:0]  cfg_end;
  logic        cfg_range_err;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  refi_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_port      (cfg_port),
    .cfg_start     (cfg_start),
    .cfg_nr_addrs  (cfg_nr_addrs),
    .cfg_init_delay(cfg_init_delay),
    .cfg_step      (cfg_step),
    .cfg_step_sign (cfg_step_sign),
    .cfg_mid_delay (cfg_mid_delay),
    .cfg_num_rept  (cfg_num_rept),
    .cfg_rep_step  (cfg_rep_step),
    .cfg_end       (cfg_end),
    .cfg_range_err (cfg_range_err),
    .err           (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] refi1(
    input logic [1:0] port, input logic [5:0] start,
    input logic [5:0] nr, input logic [5:0] init,
    input logic ext);
    return {4'b0001, port, start, nr, init, ext, 2'b00};
  endfunction

  function automatic logic [26:0] refi2(
    input logic [5:0] step, input logic sign,
    input logic [5:0] mid, input logic [5:0] rept,
    input logic [3:0] rstep);
    return {4'b0010, step, sign, mid, rept, rstep};
  endfunction

  task automatic send(input logic [26:0] w);
    instr_valid = 1'b1;
    instr       = w;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    cfg_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_valid", cfg_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_end", cfg_end, 0);

    // plain REFI1, default REFI2 fields
    send(refi1(2'd1, 6'd4, 6'd7, 6'd0, 1'b0));
    @(negedge clk);
    chk("t1_valid", cfg_valid, 1);
    chk("t1_ready", instr_ready, 0);
    chk("t1_port", cfg_port, 1);
    chk("t1_start", cfg_start, 4);
    chk("t1_step", cfg_step, 1);
    chk("t1_sign", cfg_step_sign, 0);
    chk("t1_end", cfg_end, 11);
    chk("t1_rerr", cfg_range_err, 0);
    drain();
    @(negedge clk);
    chk("t1_done_valid", cfg_valid, 0);
    chk("t1_done_ready", instr_ready, 1);

    // REFI1 with extension, gap, then REFI2
    send(refi1(2'd0, 6'd10, 6'd3, 6'd0, 1'b1));
    repeat (3) begin
      @(negedge clk);
      chk("t2_gap_valid", cfg_valid, 0);
    end
    send(refi2(6'd2, 1'b0, 6'd0, 6'd5, 4'd3));
    @(negedge clk);
    chk("t2_valid", cfg_valid, 1);
    chk("t2_step", cfg_step, 2);
    chk("t2_end", cfg_end, 16);
    chk("t2_rept", cfg_num_rept, 5);
    chk("t2_rstep", cfg_rep_step, 3);
    chk("t2_rerr", cfg_range_err, 0);
    drain();

    // negative step wraps below zero
    send(refi1(2'd0, 6'd2, 6'd3, 6'd0, 1'b1));
    send(refi2(6'd1, 1'b1, 6'd0, 6'd0, 4'd0));
    @(negedge clk);
    chk("t3_valid", cfg_valid, 1);
    chk("t3_sign", cfg_step_sign, 1);
    chk("t3_end", cfg_end, 63);
    chk("t3_rerr", cfg_range_err, 1);
    drain();

    // upper boundary exactly 63, then far overflow 4032
    send(refi1(2'd0, 6'd60, 6'd3, 6'd0, 1'b0));
    @(negedge clk);
    chk("t3b_end", cfg_end, 63);
    chk("t3b_rerr", cfg_range_err, 0);
    drain();
    send(refi1(2'd0, 6'd63, 6'd63, 6'd0, 1'b1));
    send(refi2(6'd63, 1'b0, 6'd0, 6'd0, 4'd0));
    @(negedge clk);
    chk("t3c_end", cfg_end, 0);
    chk("t3c_rerr", cfg_range_err, 1);
    drain();

    // REFI2 in IDLE
    send(refi2(6'd3, 1'b0, 6'd0, 6'd0, 4'd0));
    @(negedge clk);
    chk("t4_err", err, 1);
    chk("t4_valid", cfg_valid, 0);
    @(negedge clk);
    chk("t4_err_clr", err, 0);
    chk("t4_valid2", cfg_valid, 0);

    // REFI1 ext interrupted by a new REFI1
    send(refi1(2'd0, 6'd8, 6'd2, 6'd0, 1'b1));
    send(refi1(2'd3, 6'd20, 6'd5, 6'd0, 1'b0));
    @(negedge clk);
    chk("t4b_err", err, 1);
    chk("t4b_valid", cfg_valid, 1);
    chk("t4b_start", cfg_start, 20);
    chk("t4b_step", cfg_step, 1);
    chk("t4b_end", cfg_end, 25);
    drain();
    @(negedge clk);
    chk("t4b_err_clr", err, 0);

    // backpressure: cfg held while the next word waits
    cfg_ready = 1'b0;
    send(refi1(2'd2, 6'd30, 6'd2, 6'd9, 1'b0));
    instr_valid = 1'b1;
    instr       = refi1(2'd0, 6'd1, 6'd1, 6'd0, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("t5_ready", instr_ready, 0);
      chk("t5_valid", cfg_valid, 1);
      chk("t5_start", cfg_start, 30);
      chk("t5_init", cfg_init_delay, 9);
      chk("t5_end", cfg_end, 32);
    end
    cfg_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_hs_valid", cfg_valid, 0);
    chk("t5_hs_ready", instr_ready, 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("t5_next_valid", cfg_valid, 1);
    chk("t5_next_start", cfg_start, 1);
    chk("t5_next_end", cfg_end, 2);
    drain();

    // reset while waiting for the extension
    send(refi1(2'd1, 6'd5, 6'd1, 6'd4, 1'b1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", cfg_valid, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_start", cfg_start, 0);
    chk("t6_rst_port", cfg_port, 0);
    chk("t6_rst_end", cfg_end, 0);
    chk("t6_rst_ready", instr_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    send(refi2(6'd2, 1'b0, 6'd0, 6'd1, 4'd1));
    @(negedge clk);
    chk("t6_err", err, 1);
    chk("t6_valid", cfg_valid, 0);
    @(negedge clk);
    chk("t6_err_clr", err, 0);
    chk("t6_valid2", cfg_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
